// File: rtl/divergent_scheduler.sv
// divergent_scheduler: per-core control FSM with per-thread PCs, a live/active
// lane mask and min-PC reconvergence for divergent branches.

// One thread lane: owns its PC and live bit, exposes the post-update values
// combinationally so the core can pick the next fetch PC on the same edge.
module divergent_scheduler_lane #(
    parameter int PC_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               launch,
    input  logic               lane_en,
    input  logic               update,
    input  logic               active,
    input  logic               ret,
    input  logic [PC_BITS-1:0] next_pc,
    output logic               live_nxt,
    output logic [PC_BITS-1:0] pc_nxt
);
    logic               live_q;
    logic [PC_BITS-1:0] pc_q;

    // Next live/PC: launch reloads, UPDATE retires or advances active lanes only.
    always_comb begin
        live_nxt = live_q;
        pc_nxt   = pc_q;
        if (launch) begin
            live_nxt = lane_en;
            pc_nxt   = '0;
        end else if (update && active) begin
            if (ret) live_nxt = 1'b0;
            else     pc_nxt   = next_pc;
        end
    end

    // Lane state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q <= 1'b0;
            pc_q   <= '0;
        end else begin
            live_q <= live_nxt;
            pc_q   <= pc_nxt;
        end
    end
endmodule

module divergent_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]       thread_count,
    input  logic                                     decoded_mem_read_enable,
    input  logic                                     decoded_mem_write_enable,
    input  logic                                     decoded_ret,
    input  logic [2:0]                               fetcher_state,
    input  logic [THREADS_PER_BLOCK-1:0][1:0]        lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] next_pc,
    output logic [PC_BITS-1:0]                       current_pc,
    output logic [THREADS_PER_BLOCK-1:0]             active_mask,
    output logic [2:0]                               core_state,
    output logic                                     diverged,
    output logic                                     done
);
    localparam int T = THREADS_PER_BLOCK;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } state_t;

    state_t                       state_q, state_d;
    logic [PC_BITS-1:0]           pc_d;
    logic [T-1:0]                 mask_d;
    logic                         div_d, done_d;

    logic                         launch, update;
    logic [T-1:0]                 lane_en, lsu_busy, live_nxt, match;
    logic [T-1:0][PC_BITS-1:0]    pc_nxt;
    logic [PC_BITS-1:0]           min_pc;

    assign launch     = (state_q == IDLE) && start;
    assign update     = (state_q == UPDATE);
    assign core_state = state_q;

    // Per-lane enable, LSU busy qualification and lane instances. Counts above
    // T naturally enable every lane.
    for (genvar i = 0; i < T; i++) begin : g_lane
        assign lane_en[i]  = (int'(thread_count) > i);
        assign lsu_busy[i] = active_mask[i] &&
                             (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10);
        divergent_scheduler_lane #(.PC_BITS(PC_BITS)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .launch   (launch),
            .lane_en  (lane_en[i]),
            .update   (update),
            .active   (active_mask[i]),
            .ret      (decoded_ret),
            .next_pc  (next_pc[i]),
            .live_nxt (live_nxt[i]),
            .pc_nxt   (pc_nxt[i])
        );
    end

    // Reconvergence: smallest post-update PC among live lanes; every live lane
    // sitting at that PC runs next, which merges lanes that meet again.
    always_comb begin
        min_pc = '1;
        for (int i = 0; i < T; i++)
            if (live_nxt[i] && pc_nxt[i] < min_pc) min_pc = pc_nxt[i];
        for (int i = 0; i < T; i++)
            match[i] = live_nxt[i] && (pc_nxt[i] == min_pc);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pc_d    = current_pc;
        mask_d  = active_mask;
        div_d   = diverged;
        done_d  = done;
        case (state_q)
            IDLE: if (start) begin
                pc_d   = '0;
                mask_d = live_nxt;
                div_d  = 1'b0;
                if (thread_count == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH:   if (fetcher_state == 3'b010) state_d = DECODE;
            DECODE:  state_d = REQUEST;
            REQUEST: state_d = (decoded_mem_read_enable || decoded_mem_write_enable) ? WAIT : EXECUTE;
            WAIT:    if (lsu_busy == '0) state_d = EXECUTE;
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                if (live_nxt == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    mask_d  = '0;
                    div_d   = 1'b0;
                end else begin
                    state_d = FETCH;
                    pc_d    = min_pc;
                    mask_d  = match;
                    div_d   = |(live_nxt ^ match);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Core state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            current_pc  <= '0;
            active_mask <= '0;
            diverged    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            current_pc  <= pc_d;
            active_mask <= mask_d;
            diverged    <= div_d;
            done        <= done_d;
        end
    end
endmodule

// File: tb/tb_divergent_scheduler.sv
// Bench for divergent_scheduler: directed programs, a thread-level reference
// model checked every cycle, and literal expectations on fetch traces.
module tb_divergent_scheduler;
    localparam int T   = 4;
    localparam int PCB = 8;
    localparam int CW  = $clog2(T) + 1;

    logic                  clk = 1'b0;
    logic                  reset, start;
    logic [CW-1:0]         thread_count;
    logic                  rd, wr, ret;
    logic [2:0]            fetcher_state;
    logic [T-1:0][1:0]     lsu_state;
    logic [T-1:0][PCB-1:0] next_pc;
    logic [PCB-1:0]        current_pc;
    logic [T-1:0]          active_mask;
    logic [2:0]            core_state;
    logic                  diverged, done;

    divergent_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PCB)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .decoded_mem_read_enable(rd), .decoded_mem_write_enable(wr),
        .decoded_ret(ret), .fetcher_state(fetcher_state), .lsu_state(lsu_state),
        .next_pc(next_pc), .current_pc(current_pc), .active_mask(active_mask),
        .core_state(core_state), .diverged(diverged), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int test_id = 0;
    bit chk_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Programs: per-lane next PC, RET and memory instruction placement.
    function automatic int nxt(input int lane, input int pc);
        case (test_id)
            2: if (pc == 2) return (lane >= 2) ? 5 : 3;
            3: begin
                if (pc == 0) return (lane <= 1) ? 1 : 2;
                if (pc == 1) return 2;
            end
            5: if (pc == 0) return (lane <= 1) ? 4 : 6;
            default: ;
        endcase
        return pc + 1;
    endfunction

    function automatic bit is_ret(input int pc);
        case (test_id)
            1: return pc == 3;
            2: return pc == 5;
            3: return pc == 2;
            5: return pc == 4 || pc == 6;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_mem(input int pc);
        case (test_id)
            3: return pc == 1;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: thread PCs and live set, stepped once per clock.
    int           m_state = 0, m_pc = 0, m_wcnt = 0, m_mn = 0;
    logic [T-1:0] m_live = '0, m_mask = '0;
    bit           m_div = 1'b0, m_done = 1'b0;
    int           m_tpc[T];
    bit           m_busy;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_pc = 0; m_mask = '0; m_live = '0; m_div = 0; m_done = 0; m_wcnt = 0;
            for (int i = 0; i < T; i++) m_tpc[i] = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    for (int i = 0; i < T; i++) begin
                        m_live[i] = (i < int'(thread_count));
                        m_tpc[i]  = 0;
                    end
                    m_pc = 0; m_mask = m_live; m_div = 0;
                    if (thread_count == 0) begin m_state = 7; m_done = 1; end
                    else m_state = 1;
                end
                1: if (fetcher_state == 3'b010) m_state = 2;
                2: m_state = 3;
                3: if (rd || wr) begin m_state = 4; m_wcnt = 0; end else m_state = 5;
                4: begin
                    m_busy = 0;
                    for (int i = 0; i < T; i++)
                        if (m_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10)) m_busy = 1;
                    if (m_busy) m_wcnt++; else m_state = 5;
                end
                5: m_state = 6;
                6: begin
                    for (int i = 0; i < T; i++)
                        if (m_mask[i]) begin
                            if (ret) m_live[i] = 1'b0;
                            else     m_tpc[i]  = int'(next_pc[i]);
                        end
                    if (m_live == '0) begin
                        m_state = 7; m_done = 1; m_mask = '0; m_div = 0;
                    end else begin
                        m_mn = 1 << PCB;
                        for (int i = 0; i < T; i++)
                            if (m_live[i] && m_tpc[i] < m_mn) m_mn = m_tpc[i];
                        for (int i = 0; i < T; i++)
                            m_mask[i] = m_live[i] && (m_tpc[i] == m_mn);
                        m_pc = m_mn; m_div = (m_live != m_mask); m_state = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Environment stub: fetcher, decoder, LSUs and lane next-PC, driven from the model.
    int f_cnt = 0;
    always @(negedge clk) begin
        #1;
        if (m_state == 1) begin
            fetcher_state = (f_cnt >= 2) ? 3'b010 : 3'b000;
            f_cnt++;
        end else begin
            fetcher_state = 3'b000;
            f_cnt = 0;
        end
        ret = is_ret(m_pc);
        rd  = is_mem(m_pc) && test_id != 6;
        wr  = is_mem(m_pc) && test_id == 6;
        for (int i = 0; i < T; i++) begin
            next_pc[i] = PCB'(nxt(i, m_tpc[i]));
            lsu_state[i] = 2'b00;
            if (test_id == 6) lsu_state[i] = 2'b10;
            if (test_id == 3 && i == 2) lsu_state[i] = 2'b10;
            if (test_id == 3 && i == 1 && m_state == 4 && m_wcnt < 5)
                lsu_state[i] = (m_wcnt == 0) ? 2'b01 : 2'b10;
        end
    end

    // Per-cycle comparison and fetch-trace capture.
    typedef struct { int pc; int mask; int dv; } ent_t;
    ent_t log_q[$];
    int n_wait = 0, n_skip = 0, n_div = 0;
    logic [2:0] prev_state = 3'b000;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_state", 32'(core_state), m_state);
            chk("current_pc", 32'(current_pc), m_pc);
            chk("active_mask", 32'(active_mask), 32'(m_mask));
            chk("diverged", 32'(diverged), 32'(m_div));
            chk("done", 32'(done), 32'(m_done));
            if (core_state == 3'b010) log_q.push_back('{int'(current_pc), int'(active_mask), int'(diverged)});
            if (core_state == 3'b100) n_wait++;
            if (prev_state == 3'b011 && core_state == 3'b101) n_skip++;
            if (diverged) n_div++;
            prev_state = core_state;
        end
    end

    task automatic chk_log(input string nm, input int idx, input int pc, input int mask, input int dv);
        if (idx >= log_q.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: fetch entry %0d missing, got %0d entries", nm, idx, log_q.size());
        end else begin
            chk({nm, "_pc"}, log_q[idx].pc, pc);
            chk({nm, "_mask"}, log_q[idx].mask, mask);
            chk({nm, "_div"}, log_q[idx].dv, dv);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int k;
        k = 0;
        while (m_state != s && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (m_state != s) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout, state %0d required %0d", nm, m_state, s);
        end
    endtask

    task automatic run_block(input int tid, input int tc);
        log_q.delete(); n_wait = 0; n_skip = 0; n_div = 0;
        test_id = tid; thread_count = CW'(tc); start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_state(7, 400, "run_done");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_count = '0; rd = 0; wr = 0; ret = 0;
        fetcher_state = 3'b000; lsu_state = '0; next_pc = '0;
        @(negedge clk);
        chk("rst_state", 32'(core_state), 0);
        chk("rst_mask", 32'(active_mask), 0);
        chk("rst_done", 32'(done), 0);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        // T1/T4: uniform block, RET at pc 3, no memory ops.
        run_block(1, 4);
        chk("t1_count", log_q.size(), 4);
        for (int k = 0; k < 4; k++) chk_log("t1_fetch", k, k, 4'hF, 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_final_pc", 32'(current_pc), 3);
        chk("t1_never_div", n_div, 0);
        chk("t4_no_wait", n_wait, 0);
        chk("t4_req_to_exe", n_skip, 4);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("done_ignores_start", 32'(core_state), 7);
        do_reset();

        // T2: divergence at pc 2 and reconvergence at pc 5.
        run_block(2, 4);
        chk("t2_count", log_q.size(), 6);
        chk_log("t2_f2", 2, 2, 4'hF, 0);
        chk_log("t2_f3", 3, 3, 4'h3, 1);
        chk_log("t2_f4", 4, 4, 4'h3, 1);
        chk_log("t2_f5", 5, 5, 4'hF, 0);
        do_reset();

        // T3: memory op with an active waiting lane and an inactive stuck lane.
        run_block(3, 4);
        chk_log("t3_f1", 1, 1, 4'h3, 1);
        chk_log("t3_f2", 2, 2, 4'hF, 0);
        chk("t3_wait_cycles", n_wait, 6);
        do_reset();

        // T5: lanes 0,1 retire first, lanes 2,3 finish later.
        run_block(5, 4);
        chk("t5_count", log_q.size(), 3);
        chk_log("t5_f1", 1, 4, 4'h3, 1);
        chk_log("t5_f2", 2, 6, 4'hC, 0);
        chk("t5_done", 32'(done), 1);
        do_reset();

        // Saturating thread count.
        run_block(1, 7);
        chk_log("sat_f0", 0, 0, 4'hF, 0);
        do_reset();

        // T6: empty block, partial block, reset while waiting.
        test_id = 0; thread_count = '0; start = 1'b1;
        @(negedge clk);
        chk("t6_zero_state", 32'(core_state), 7);
        chk("t6_zero_done", 32'(done), 1);
        #1 start = 1'b0;
        do_reset();
        test_id = 6; thread_count = CW'(3); start = 1'b1;
        @(negedge clk);
        chk("t6_three_state", 32'(core_state), 1);
        chk("t6_three_mask", 32'(active_mask), 32'h7);
        #1 start = 1'b0;
        wait_state(4, 50, "t6_reach_wait");
        repeat (2) begin @(negedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_state", 32'(core_state), 0);
        chk("t6_rst_mask", 32'(active_mask), 0);
        chk("t6_rst_div", 32'(diverged), 0);
        #1 reset = 1'b0;
        test_id = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
